// File: rtl/cpu_ctl_pkg.sv
// Shared types and encodings for the hardwired control sequencer.
package cpu_ctl_pkg;

  // Sequencer states: fetch (T0, T1, FMEM, T2), execute (T3..T7), and the two traps.
  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_FMEM,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT,
    ST_FAULT
  } state_e;

  // Native width of the opcode and ALU operation encodings below.
  localparam int OPC_W = 5;

  // Opcode field encodings.
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // ALU operation driven during the address/offset add slots.
  localparam logic [OPC_W-1:0] ALU_ADD  = 5'b00011;

  // One-hot view of the current opcode; bad marks any undefined encoding.
  typedef struct packed {
    logic ld;
    logic ldi;
    logic st;
    logic addi;
    logic br;
    logic nop;
    logic halt;
    logic bad;
  } opc_dec_t;

endpackage

// File: rtl/ctl_mem_wait.sv
// Memory-wait timeout counter. Held at zero (reloaded) whenever load_i is
// high, i.e. outside a wait state; counts wait cycles otherwise and flags
// expire_o during the TIMEOUT-th consecutive wait cycle. TIMEOUT=0 disables it.
module ctl_mem_wait #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on load, otherwise advance and saturate at the last wait slot.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT > 0) && !load_i && (cnt_q == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for data_path: fetch, per-opcode execute,
// memory-ready handshake with bounded wait, halt and illegal-opcode report.
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 16,
  parameter int IR_W    = 32
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [IR_W-1:0] irOut,
  input  logic            mem_ready,
  input  logic            branchCompare,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            Rout,
  output logic            BAOut,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            ZHighin,
  output logic            Rin,
  output logic            CONin,
  output logic            IncPC,
  output logic            Gra,
  output logic            Grb,
  output logic            Read,
  output logic            Write,
  output logic [OP_W-1:0] op,
  output logic            run,
  output logic            illegal,
  output logic            fault
);

  state_e          state_q;
  state_e          state_d;
  opc_dec_t        dec;
  logic [OP_W-1:0] opcode;
  logic            mem_wait;
  logic            wait_load;
  logic            expire;
  logic            unused_ir;

  assign opcode    = irOut[IR_W-1 -: OP_W];
  assign unused_ir = ^irOut[IR_W-OP_W-1:0];

  // Opcode decode into one-hot flags; anything unlisted is illegal.
  always_comb begin
    dec      = '0;
    dec.ld   = (opcode == OP_W'(OPC_LD));
    dec.ldi  = (opcode == OP_W'(OPC_LDI));
    dec.st   = (opcode == OP_W'(OPC_ST));
    dec.addi = (opcode == OP_W'(OPC_ADDI));
    dec.br   = (opcode == OP_W'(OPC_BR));
    dec.nop  = (opcode == OP_W'(OPC_NOP));
    dec.halt = (opcode == OP_W'(OPC_HALT));
    dec.bad  = !(dec.ld || dec.ldi || dec.st || dec.addi || dec.br || dec.nop || dec.halt);
  end

  // The three handshake states; the timeout counter reloads whenever we are outside them.
  assign mem_wait  = (state_q == ST_FMEM) ||
                     ((state_q == ST_T6) && dec.ld) ||
                     ((state_q == ST_T7) && dec.st);
  assign wait_load = !mem_wait;

  ctl_mem_wait #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait (
    .clk_i    (Clock),
    .clear_i  (clear),
    .load_i   (wait_load),
    .expire_o (expire)
  );

  // Next-state sequencing; wait states hold until mem_ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_FMEM;
      ST_FMEM: begin
        if (mem_ready)   state_d = ST_T2;
        else if (expire) state_d = ST_FAULT;
      end
      ST_T2: begin
        if (dec.halt)               state_d = ST_HALT;
        else if (dec.nop || dec.bad) state_d = ST_T0;
        else                         state_d = ST_T3;
      end
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (dec.ldi || dec.addi) ? ST_T0 : ST_T6;
      ST_T6: begin
        if (dec.ld) begin
          if (mem_ready)   state_d = ST_T7;
          else if (expire) state_d = ST_FAULT;
        end else if (dec.st) begin
          state_d = ST_T7;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T7: begin
        if (dec.st) begin
          if (mem_ready)   state_d = ST_T0;
          else if (expire) state_d = ST_FAULT;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST;
    endcase
  end

  // State register; clear aborts any instruction or wait on the next edge.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe decode from the state register; only MDRin/PCin follow mem_ready/branchCompare.
  always_comb begin
    {PCout, Zlowout, MDRout, Cout, Rout, BAOut}                 = '0;
    {MARin, PCin, MDRin, IRin, Yin, Zlowin, ZHighin, Rin, CONin} = '0;
    {IncPC, Gra, Grb, Read, Write}                               = '0;
    op      = '0;
    run     = 1'b1;
    illegal = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_T0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; ZHighin = 1'b1; end
      ST_T1:   begin Zlowout = 1'b1; PCin = 1'b1; end
      ST_FMEM: begin Read = 1'b1; MDRin = mem_ready; end
      ST_T2:   begin MDRout = 1'b1; IRin = 1'b1; illegal = dec.bad; end
      ST_T3: begin
        if (dec.br)        begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (dec.addi) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else               begin Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; end
      end
      ST_T4: begin
        if (dec.br) begin PCout = 1'b1; Yin = 1'b1; end
        else        begin Cout = 1'b1; op = OP_W'(ALU_ADD); Zlowin = 1'b1; end
      end
      ST_T5: begin
        if (dec.br)                    begin Cout = 1'b1; op = OP_W'(ALU_ADD); Zlowin = 1'b1; end
        else if (dec.ldi || dec.addi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else                           begin Zlowout = 1'b1; MARin = 1'b1; end
      end
      ST_T6: begin
        if (dec.ld)      begin Read = 1'b1; MDRin = mem_ready; end
        else if (dec.st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else             begin Zlowout = 1'b1; PCin = branchCompare; end
      end
      ST_T7: begin
        if (dec.ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else        Write = 1'b1;
      end
      ST_HALT:  run = 1'b0;
      ST_FAULT: begin run = 1'b0; fault = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed strobe vectors per cycle.
module tb_control_sequencer;

  localparam int OP_W    = 5;
  localparam int TIMEOUT = 16;
  localparam int IR_W    = 32;

  // Strobe bit masks, in the order of the observed vector below.
  localparam logic [19:0] NONE    = 20'h00000;
  localparam logic [19:0] PCOUT   = 20'h80000;
  localparam logic [19:0] ZLOWOUT = 20'h40000;
  localparam logic [19:0] MDROUT  = 20'h20000;
  localparam logic [19:0] COUT    = 20'h10000;
  localparam logic [19:0] ROUT    = 20'h08000;
  localparam logic [19:0] BAOUT   = 20'h04000;
  localparam logic [19:0] MARIN   = 20'h02000;
  localparam logic [19:0] PCIN    = 20'h01000;
  localparam logic [19:0] MDRIN   = 20'h00800;
  localparam logic [19:0] IRIN    = 20'h00400;
  localparam logic [19:0] YIN     = 20'h00200;
  localparam logic [19:0] ZLOWIN  = 20'h00100;
  localparam logic [19:0] ZHIGHIN = 20'h00080;
  localparam logic [19:0] RIN     = 20'h00040;
  localparam logic [19:0] CONIN   = 20'h00020;
  localparam logic [19:0] INCPC   = 20'h00010;
  localparam logic [19:0] GRA     = 20'h00008;
  localparam logic [19:0] GRB     = 20'h00004;
  localparam logic [19:0] READ    = 20'h00002;
  localparam logic [19:0] WRITE   = 20'h00001;

  localparam logic [4:0] ADD     = 5'b00011;
  // Flags {run, illegal, fault}.
  localparam logic [2:0] F_RUN   = 3'b100;
  localparam logic [2:0] F_ILL   = 3'b110;
  localparam logic [2:0] F_HALT  = 3'b000;
  localparam logic [2:0] F_FAULT = 3'b001;

  logic            Clock = 1'b0;
  logic            clear = 1'b1;
  logic            mem_ready = 1'b0;
  logic            branchCompare = 1'b0;
  logic [IR_W-1:0] irOut = '0;

  logic PCout, Zlowout, MDRout, Cout, Rout, BAOut;
  logic MARin, PCin, MDRin, IRin, Yin, Zlowin, ZHighin, Rin, CONin, IncPC;
  logic Gra, Grb, Read, Write;
  logic [OP_W-1:0] op;
  logic run, illegal, fault;
  logic [27:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  control_sequencer #(
    .OP_W    (OP_W),
    .TIMEOUT (TIMEOUT),
    .IR_W    (IR_W)
  ) dut (
    .Clock         (Clock),
    .clear         (clear),
    .irOut         (irOut),
    .mem_ready     (mem_ready),
    .branchCompare (branchCompare),
    .PCout         (PCout),
    .Zlowout       (Zlowout),
    .MDRout        (MDRout),
    .Cout          (Cout),
    .Rout          (Rout),
    .BAOut         (BAOut),
    .MARin         (MARin),
    .PCin          (PCin),
    .MDRin         (MDRin),
    .IRin          (IRin),
    .Yin           (Yin),
    .Zlowin        (Zlowin),
    .ZHighin       (ZHighin),
    .Rin           (Rin),
    .CONin         (CONin),
    .IncPC         (IncPC),
    .Gra           (Gra),
    .Grb           (Grb),
    .Read          (Read),
    .Write         (Write),
    .op            (op),
    .run           (run),
    .illegal       (illegal),
    .fault         (fault)
  );

  assign obs = {PCout, Zlowout, MDRout, Cout, Rout, BAOut, MARin, PCin, MDRin, IRin,
                Yin, Zlowin, ZHighin, Rin, CONin, IncPC, Gra, Grb, Read, Write,
                op, run, illegal, fault};

  always #5 Clock = ~Clock;

  // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
  task automatic cyc(input string tag, input logic clr, input logic rdy, input logic bc,
                     input logic [19:0] s, input logic [4:0] o = 5'd0,
                     input logic [2:0] f = F_RUN);
    logic [27:0] exp_v;
    @(posedge Clock);
    #1;
    clear         = clr;
    mem_ready     = rdy;
    branchCompare = bc;
    @(negedge Clock);
    exp_v = {s, o, f};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Fetch with zero-wait memory; IR changes only once T0 is under way.
  task automatic fetch(input string tag, input logic [IR_W-1:0] ir, input logic [2:0] t2f = F_RUN);
    cyc({tag, "_t0"}, 1'b0, 1'b0, 1'b0, PCOUT | MARIN | INCPC | ZLOWIN | ZHIGHIN);
    irOut = ir;
    cyc({tag, "_t1"},   1'b0, 1'b0, 1'b0, ZLOWOUT | PCIN);
    cyc({tag, "_fmem"}, 1'b0, 1'b1, 1'b0, READ | MDRIN);
    cyc({tag, "_t2"},   1'b0, 1'b0, 1'b0, MDROUT | IRIN, 5'd0, t2f);
  endtask

  initial begin
    // Reset: RST outputs all zero with run high; mem_ready ignored.
    cyc("rst_hold", 1'b1, 1'b0, 1'b0, NONE);
    cyc("rst_rel",  1'b0, 1'b1, 1'b1, NONE);

    // ld r1,0x55(r0), mem_ready always 1: 9 cycles.
    fetch("ld", 32'h00800055);
    cyc("ld_t3", 1'b0, 1'b1, 1'b0, GRB | BAOUT | YIN);
    cyc("ld_t4", 1'b0, 1'b1, 1'b0, COUT | ZLOWIN, ADD);
    cyc("ld_t5", 1'b0, 1'b1, 1'b0, ZLOWOUT | MARIN);
    cyc("ld_t6", 1'b0, 1'b1, 1'b0, READ | MDRIN);
    cyc("ld_t7", 1'b0, 1'b1, 1'b0, MDROUT | GRA | RIN);

    // st r1,0x87(r0), mem_ready late by 3 cycles: Write held 4 cycles.
    fetch("st", 32'h10800087);
    cyc("st_t3",  1'b0, 1'b0, 1'b0, GRB | BAOUT | YIN);
    cyc("st_t4",  1'b0, 1'b0, 1'b0, COUT | ZLOWIN, ADD);
    cyc("st_t5",  1'b0, 1'b0, 1'b0, ZLOWOUT | MARIN);
    cyc("st_t6",  1'b0, 1'b0, 1'b0, GRA | ROUT | MDRIN);
    cyc("st_w1",  1'b0, 1'b0, 1'b0, WRITE);
    cyc("st_w2",  1'b0, 1'b0, 1'b0, WRITE);
    cyc("st_w3",  1'b0, 1'b0, 1'b0, WRITE);
    cyc("st_w4",  1'b0, 1'b1, 1'b0, WRITE);

    // br not taken, then taken.
    fetch("br0", 32'h90000000);
    cyc("br0_t3", 1'b0, 1'b0, 1'b1, GRA | ROUT | CONIN);
    cyc("br0_t4", 1'b0, 1'b0, 1'b1, PCOUT | YIN);
    cyc("br0_t5", 1'b0, 1'b0, 1'b1, COUT | ZLOWIN, ADD);
    cyc("br0_t6", 1'b0, 1'b0, 1'b0, ZLOWOUT);
    fetch("br1", 32'h90000000);
    cyc("br1_t3", 1'b0, 1'b0, 1'b0, GRA | ROUT | CONIN);
    cyc("br1_t4", 1'b0, 1'b0, 1'b0, PCOUT | YIN);
    cyc("br1_t5", 1'b0, 1'b0, 1'b0, COUT | ZLOWIN, ADD);
    cyc("br1_t6", 1'b0, 1'b0, 1'b1, ZLOWOUT | PCIN);

    // addi and ldi: 7 cycles each.
    fetch("addi", 32'h60000000);
    cyc("addi_t3", 1'b0, 1'b0, 1'b0, GRB | ROUT | YIN);
    cyc("addi_t4", 1'b0, 1'b0, 1'b0, COUT | ZLOWIN, ADD);
    cyc("addi_t5", 1'b0, 1'b0, 1'b0, ZLOWOUT | GRA | RIN);
    fetch("ldi", 32'h08000000);
    cyc("ldi_t3", 1'b0, 1'b0, 1'b0, GRB | BAOUT | YIN);
    cyc("ldi_t4", 1'b0, 1'b0, 1'b0, COUT | ZLOWIN, ADD);
    cyc("ldi_t5", 1'b0, 1'b0, 1'b0, ZLOWOUT | GRA | RIN);

    // Undefined opcode pulses illegal in T2 only; nop returns straight to T0.
    fetch("ill", 32'hF8000000, F_ILL);
    fetch("nop", 32'hD0000000);

    // clear during ld T5 aborts to RST; fetch restarts.
    fetch("ab", 32'h00800055);
    cyc("ab_t3",  1'b0, 1'b0, 1'b0, GRB | BAOUT | YIN);
    cyc("ab_t4",  1'b0, 1'b0, 1'b0, COUT | ZLOWIN, ADD);
    cyc("ab_t5",  1'b1, 1'b0, 1'b0, ZLOWOUT | MARIN);
    cyc("ab_rst", 1'b0, 1'b0, 1'b0, NONE);

    // Fetch memory never ready: 16 wait cycles, then FAULT until clear.
    cyc("to_t0", 1'b0, 1'b0, 1'b0, PCOUT | MARIN | INCPC | ZLOWIN | ZHIGHIN);
    irOut = 32'hD0000000;
    cyc("to_t1", 1'b0, 1'b0, 1'b0, ZLOWOUT | PCIN);
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc("to_wait", 1'b0, 1'b0, 1'b0, READ);
    end
    cyc("to_fault", 1'b0, 1'b1, 1'b0, NONE, 5'd0, F_FAULT);
    cyc("to_hold",  1'b0, 1'b1, 1'b0, NONE, 5'd0, F_FAULT);
    cyc("to_clr",   1'b1, 1'b0, 1'b0, NONE, 5'd0, F_FAULT);
    cyc("to_rst",   1'b0, 1'b0, 1'b0, NONE);

    // HALT: run low and held until clear.
    fetch("halt", 32'hD8000000);
    cyc("halt_1",   1'b0, 1'b1, 1'b1, NONE, 5'd0, F_HALT);
    cyc("halt_2",   1'b0, 1'b0, 1'b0, NONE, 5'd0, F_HALT);
    cyc("halt_clr", 1'b1, 1'b0, 1'b0, NONE, 5'd0, F_HALT);
    cyc("halt_rst", 1'b0, 1'b0, 1'b0, NONE);
    cyc("halt_t0",  1'b0, 1'b0, 1'b0, PCOUT | MARIN | INCPC | ZLOWIN | ZHIGHIN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
